cnn_frame_sequencer: RTL and testbench

CNN_FRAME_SEQUENCER -- requirements
Module: cnn_frame_sequencer

---
 rtl/cnn_pkg.sv | 19 +
 rtl/cnn_seq_addr_gen.sv | 47 ++++
 rtl/cnn_frame_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN frame sequencer.
// The top module takes its default geometry from here.
package cnn_pkg;

  localparam int IX           = 28;
  localparam int IY           = 28;
  localparam int KX           = 5;
  localparam int KY           = 5;
  localparam int PIX_PER_IMG  = IX * IY;
  localparam int CONV_PER_IMG = (IX - KX + 1) * (IY - KY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/cnn_seq_addr_gen.sv
// Pixel index counter producing the ROM address base(sel) + idx
// and a flag marking the final pixel of the image.
module cnn_seq_addr_gen #(
  parameter int PIX    = 784,
  parameter int SEL_W  = 4,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  sel,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int IDX_W = $clog2(PIX + 1);

  logic [IDX_W-1:0] idx_q, idx_d;

  // Next pixel index: cleared on frame start, stepped on each issued read.
  always_comb begin
    if (clear) begin
      idx_d = '0;
    end else if (advance) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Pixel index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Address and last-pixel decode from the current index.
  always_comb begin
    addr = ADDR_W'(sel) * ADDR_W'(PIX) + ADDR_W'(idx_q);
    last = (idx_q == IDX_W'(PIX - 1));
  end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer: streams one image from the pixel ROM into the conv core and
// waits for conv/classifier completion. Optional watchdog: CNN_SEQ_TIMEOUT_EN.
module cnn_frame_sequencer #(
  parameter int IX          = cnn_pkg::IX,
  parameter int IY          = cnn_pkg::IY,
  parameter int KX          = cnn_pkg::KX,
  parameter int KY          = cnn_pkg::KY,
  parameter int NUM_IMG     = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int ADDR_W      = $clog2(NUM_IMG * IX * IY)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [3:0]        i_sel,
  input  logic              i_ready,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_pix_valid,
  input  logic              i_conv_valid,
  input  logic              i_result_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [9:0]        o_conv_cnt
);

  import cnn_pkg::*;

  localparam int         PIX_N    = IX * IY;
  localparam int         CONV_N   = (IX - KX + 1) * (IY - KY + 1);
  localparam logic [9:0] CONV_MAX = 10'(CONV_N);

  seq_state_e        state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [9:0]        cnt_q, cnt_d;
  logic              flag_q, flag_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              pix_valid_q, pix_valid_d;

  logic              accept_s, issue_s, last_s, finish_s, timeout_s;
  logic [ADDR_W-1:0] gen_addr_s;

  cnn_seq_addr_gen #(
    .PIX    (PIX_N),
    .SEL_W  (4),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel_q),
    .clear   (accept_s),
    .advance (issue_s),
    .addr    (gen_addr_s),
    .last    (last_s)
  );

  // Frame bookkeeping: start acceptance, read issue, conv count and result flag.
  always_comb begin
    accept_s = (state_q == IDLE) && i_start;
    issue_s  = (state_q == LOAD) && i_ready;
    sel_d    = accept_s ? i_sel : sel_q;

    if (accept_s) begin
      cnt_d = '0;
    end else if (((state_q == LOAD) || (state_q == WAIT)) && i_conv_valid && (cnt_q != CONV_MAX)) begin
      cnt_d = cnt_q + 10'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (accept_s) begin
      flag_d = 1'b0;
    end else if ((state_q != IDLE) && i_result_valid) begin
      flag_d = 1'b1;
    end else begin
      flag_d = flag_q;
    end

    // Uses next-cycle values so conv completion and result may coincide.
    finish_s    = (state_q == WAIT) && (cnt_d == CONV_MAX) && flag_d;
    rd_en_d     = issue_s;
    rd_addr_d   = issue_s ? gen_addr_s : rd_addr_q;
    pix_valid_d = rd_en_q;
  end

`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Watchdog: counts consecutive WAIT cycles with no conv or result activity.
  always_comb begin
    if ((state_q == WAIT) && !i_conv_valid && !i_result_valid) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = '0;
    end
    timeout_s = (state_q == WAIT) && !finish_s && (wd_d == WD_W'(TIMEOUT_CYC));
    if (accept_s) begin
      err_d = 1'b0;
    end else if (timeout_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Watchdog and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign o_error = err_q;
`else
  assign timeout_s = 1'b0;
  assign o_error   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = LOAD;
        else         state_d = IDLE;
      end
      LOAD: begin
        if (issue_s && last_s) state_d = WAIT;
        else                   state_d = LOAD;
      end
      WAIT: begin
        if (finish_s)       state_d = DONE;
        else if (timeout_s) state_d = IDLE;
        else                state_d = WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_busy = (state_q != IDLE);
    o_done = (state_q == DONE);
  end

  // Datapath registers; in-flight pixel valid is dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= 4'd0;
      cnt_q       <= 10'd0;
      flag_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign o_rd_en     = rd_en_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_pix_valid = pix_valid_q;
  assign o_conv_cnt  = cnt_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: expected ROM addresses and done
// pulses are queued by the stimulus and consumed by a negedge monitor.
module tb_cnn_frame_sequencer;

  localparam int PIX  = 28 * 28;
  localparam int CONV = 24 * 24;
  localparam int TO   = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [3:0]  i_sel = 4'd0;
  logic        i_ready = 1'b0;
  logic        o_rd_en;
  logic [13:0] o_rd_addr;
  logic        o_pix_valid;
  logic        i_conv_valid = 1'b0;
  logic        i_result_valid = 1'b0;
  logic        o_busy, o_done, o_error;
  logic [9:0]  o_conv_cnt;

  cnn_frame_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_sel          (i_sel),
    .i_ready        (i_ready),
    .o_rd_en        (o_rd_en),
    .o_rd_addr      (o_rd_addr),
    .o_pix_valid    (o_pix_valid),
    .i_conv_valid   (i_conv_valid),
    .i_result_valid (i_result_valid),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_conv_cnt     (o_conv_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_addr[$];
  int exp_done[$];
  int pops = 0;
  bit prev_rd = 1'b0;
  bit after_done = 1'b0;

  // reference model of the running frame
  int cnt_m = 0;
  bit flag_m = 1'b0;
  bit active_m = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes reads and done pulses as the DUT presents them.
  always @(negedge clk) begin
    if (o_rd_en) begin
      pops++;
      if (exp_addr.size() == 0) chk("rd_unexpected", int'(o_rd_addr), -1);
      else chk("rd_addr", int'(o_rd_addr), exp_addr.pop_front());
    end
    if (!reset && (o_pix_valid || prev_rd)) chk("pix_lag", int'(o_pix_valid), int'(prev_rd));
    prev_rd = reset ? 1'b0 : o_rd_en;
    if (after_done) begin
      chk("done_width", int'(o_done), 0);
      chk("busy_after_done", int'(o_busy), 0);
      after_done = 1'b0;
    end else if (o_done) begin
      chk("done_expected", int'(exp_done.size() > 0), 1);
      if (exp_done.size() > 0) void'(exp_done.pop_front());
      after_done = 1'b1;
    end
`ifndef CNN_SEQ_TIMEOUT_EN
    if (o_error !== 1'b0) chk("error_tied", int'(o_error), 0);
`endif
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_event(input bit conv, input bit res);
    if (active_m) begin
      if (conv && cnt_m < CONV) cnt_m++;
      if (res) flag_m = 1'b1;
      if (cnt_m == CONV && flag_m) begin
        exp_done.push_back(1);
        active_m = 1'b0;
      end
    end
  endtask

  task automatic start_frame(input int sel);
    for (int k = 0; k < PIX; k++) exp_addr.push_back(sel * PIX + k);
    i_start = 1'b1;
    i_sel = 4'(sel);
    cycle();
    i_start = 1'b0;
    cnt_m = 0;
    flag_m = 1'b0;
    active_m = 1'b1;
    chk("busy_on_start", int'(o_busy), 1);
  endtask

  // mode 0: ready always, 1: toggle every 3 cycles, 2: random
  task automatic run_load(input int mode);
    int c = 0;
    while (exp_addr.size() != 0 && c < 5000) begin
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ((c / 3) % 2) == 0;
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      i_start = (mode == 1) && (c == 50);
      i_sel = (mode == 1) ? 4'd9 : i_sel;
      cycle();
      i_start = 1'b0;
      c++;
    end
    i_ready = 1'b0;
    if (c >= 5000) chk("load_timeout", exp_addr.size(), 0);
  endtask

  task automatic send_conv(input int n, input bit res_on_last);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cycle();
      i_conv_valid = 1'b1;
      i_result_valid = res_on_last && (i == n - 1);
      cycle();
      model_event(1'b1, i_result_valid);
      i_conv_valid = 1'b0;
      i_result_valid = 1'b0;
      chk("conv_cnt", int'(o_conv_cnt), cnt_m);
    end
  endtask

  task automatic send_result();
    i_result_valid = 1'b1;
    cycle();
    model_event(1'b0, 1'b1);
    i_result_valid = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    while (exp_done.size() != 0 && c < 200) begin
      cycle();
      c++;
    end
    if (c >= 200) chk("done_timeout", exp_done.size(), 0);
    repeat (3) cycle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) cycle();
    reset = 1'b0;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_rd_en", int'(o_rd_en), 0);
    chk("rst_rd_addr", int'(o_rd_addr), 0);
    chk("rst_pix_valid", int'(o_pix_valid), 0);
    chk("rst_error", int'(o_error), 0);
    chk("rst_conv_cnt", int'(o_conv_cnt), 0);
    cycle();

    // sel=2, ready held: addresses 1568..2351, result with last conv pulse
    start_frame(2);
    run_load(0);
    send_conv(CONV, 1'b1);
    wait_done();

    // ready toggling, stray start mid-load, result early, conv overrun
    start_frame(int'($urandom_range(0, 15)));
    run_load(1);
    send_result();
    send_conv(600, 1'b0);
    chk("conv_saturated", int'(o_conv_cnt), CONV);
    wait_done();

    // result in IDLE is ignored; frame then waits for its own result
    send_result();
    start_frame(int'($urandom_range(0, 15)));
    run_load(2);
    send_conv(CONV, 1'b0);
    chk("wait_for_result", int'(o_busy), 1);
`ifndef CNN_SEQ_TIMEOUT_EN
    repeat (100) cycle();
    chk("stall_busy", int'(o_busy), 1);
`endif
    send_result();
    wait_done();

    // reset mid-frame around idx 300, then restart from base
    start_frame(5);
    pops = 0;
    begin
      int c = 0;
      i_ready = 1'b1;
      while (pops < 300 && c < 2000) begin
        cycle();
        c++;
      end
      if (c >= 2000) chk("pop_timeout", pops, 300);
    end
    reset = 1'b1;
    i_ready = 1'b0;
    cycle();
    reset = 1'b0;
    exp_addr.delete();
    active_m = 1'b0;
    chk("midrst_pix_valid", int'(o_pix_valid), 0);
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_conv_cnt", int'(o_conv_cnt), 0);
    repeat (5) cycle();
    start_frame(5);
    run_load(0);
    send_conv(CONV, 1'b1);
    wait_done();

`ifdef CNN_SEQ_TIMEOUT_EN
    // watchdog expiry with no activity after load
    begin
      int n = 1;
      start_frame(7);
      run_load(0);
      while (!o_error && n < 1000) begin
        cycle();
        n++;
      end
      chk("timeout_cycles", n, TO);
      chk("timeout_error", int'(o_error), 1);
      chk("timeout_idle", int'(o_busy), 0);
      start_frame(7);
      chk("error_cleared", int'(o_error), 0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      exp_addr.delete();
      active_m = 1'b0;
      repeat (3) cycle();
    end
`endif

    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
